// File: rtl/exibidor_sequencia_pkg.sv
// Shared types for the sequence playback engine: FSM state encoding (also
// exported on db_estado for the 7-segment debug display) and timer sizing.
package exibidor_sequencia_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO   = 4'd0,
    ENDERECA = 4'd1,
    CAPTURA  = 4'd2,
    ACESO    = 4'd3,
    APAGADO  = 4'd4,
    PROXIMO  = 4'd5,
    FIM      = 4'd6
  } estado_t;

  // Width that can hold max(on, off) cycles, shared by both intervals.
  function automatic int largura_timer(input int on_ciclos, input int off_ciclos);
    int maior;
    maior = (on_ciclos > off_ciclos) ? on_ciclos : off_ciclos;
    return $clog2(maior + 1);
  endfunction

endpackage

// File: rtl/exibidor_sequencia_if.sv
// Bundle between the control unit / RAM / LED side and the playback engine.
// The engine takes the slave view; the surrounding game logic takes the master view.
interface exibidor_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);

  logic                                     iniciar;
  logic                                     abortar;
  logic [ADDR_W-1:0]                        rodada;
  logic [ADDR_W-1:0]                        mem_addr;
  logic [DATA_W-1:0]                        mem_dado;
  logic [DATA_W-1:0]                        leds;
  logic                                     ocupado;
  logic                                     pronto;
  logic [exibidor_sequencia_pkg::ESTADO_W-1:0] db_estado;
  logic [ADDR_W-1:0]                        db_indice;

  modport master (
    output iniciar, abortar, rodada, mem_dado,
    input  mem_addr, leds, ocupado, pronto, db_estado, db_indice
  );

  modport slave (
    input  iniciar, abortar, rodada, mem_dado,
    output mem_addr, leds, ocupado, pronto, db_estado, db_indice
  );

endinterface

// File: rtl/exibidor_sequencia_temporizador_exibicao.sv
// Cycle counter for the lit and blank intervals: cleared by zera, advanced by
// conta, and reporting fim while the count equals limite.
module temporizador_exibicao #(
  parameter int TIMER_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [TIMER_W-1:0] limite,
  output logic               fim
);

  logic [TIMER_W-1:0] contagem_q;
  logic [TIMER_W-1:0] contagem_d;

  // Clearing wins over counting so the FSM can restart the interval on the
  // same cycle the previous one ends.
  always_comb begin
    contagem_d = contagem_q;
    if (zera) begin
      contagem_d = '0;
    end else if (conta) begin
      contagem_d = contagem_q + TIMER_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign fim = (contagem_q == limite);

endmodule

// File: rtl/exibidor_sequencia.sv
// Sequence playback engine: walks RAM addresses 0..rodada, lights each value on
// leds for ON_CICLOS cycles, blanks for OFF_CICLOS cycles, then pulses pronto.
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int ON_CICLOS  = 500,
  parameter int OFF_CICLOS = 250,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  exibidor_sequencia_if.slave  bus
);

  localparam int                 TIMER_W    = largura_timer(ON_CICLOS, OFF_CICLOS);
  localparam logic [TIMER_W-1:0] LIMITE_ON  = TIMER_W'(ON_CICLOS - 1);
  localparam logic [TIMER_W-1:0] LIMITE_OFF = TIMER_W'(OFF_CICLOS - 1);

  estado_t             estado_q,   estado_d;
  logic [ADDR_W-1:0]   indice_q,   indice_d;
  logic [ADDR_W-1:0]   rodada_q,   rodada_d;
  logic [DATA_W-1:0]   dado_q,     dado_d;
  logic [DATA_W-1:0]   leds_q,     leds_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                ocupado_q,  ocupado_d;
  logic                pronto_q,   pronto_d;

  logic                timer_zera;
  logic                timer_conta;
  logic                timer_fim;
  logic [TIMER_W-1:0]  timer_limite;

  temporizador_exibicao #(
    .TIMER_W (TIMER_W)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .zera   (timer_zera),
    .conta  (timer_conta),
    .limite (timer_limite),
    .fim    (timer_fim)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    estado_d     = estado_q;
    indice_d     = indice_q;
    rodada_d     = rodada_q;
    dado_d       = dado_q;
    timer_zera   = 1'b0;
    timer_conta  = 1'b0;
    timer_limite = LIMITE_ON;

    if (bus.abortar && (estado_q != OCIOSO)) begin
      estado_d   = OCIOSO;
      indice_d   = '0;
      timer_zera = 1'b1;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.iniciar && !bus.abortar) begin
            rodada_d = bus.rodada;
            indice_d = '0;
            estado_d = ENDERECA;
          end
        end
        ENDERECA: estado_d = CAPTURA;
        CAPTURA: begin
          dado_d     = bus.mem_dado;
          timer_zera = 1'b1;
          estado_d   = ACESO;
        end
        ACESO: begin
          timer_conta = 1'b1;
          if (timer_fim) begin
            timer_zera = 1'b1;
            estado_d   = APAGADO;
          end
        end
        APAGADO: begin
          timer_limite = LIMITE_OFF;
          timer_conta  = 1'b1;
          if (timer_fim) begin
            timer_zera = 1'b1;
            estado_d   = PROXIMO;
          end
        end
        PROXIMO: begin
          // Compare before incrementing so rodada = 2**ADDR_W - 1 never wraps.
          if (indice_q == rodada_q) begin
            estado_d = FIM;
          end else begin
            indice_d = indice_q + ADDR_W'(1);
            estado_d = ENDERECA;
          end
        end
        FIM: begin
          indice_d = '0;
          estado_d = OCIOSO;
        end
        default: estado_d = OCIOSO;
      endcase
    end

    // Visible outputs follow the current state one cycle later; an abort
    // blanks them on the same edge that returns the FSM to OCIOSO.
    leds_d    = (estado_q == ACESO && !bus.abortar) ? dado_q : '0;
    pronto_d  = (estado_q == FIM) && !bus.abortar;
    ocupado_d = (estado_q != OCIOSO) && !bus.abortar;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      indice_q   <= '0;
      rodada_q   <= '0;
      dado_q     <= '0;
      leds_q     <= '0;
      mem_addr_q <= '0;
      ocupado_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      indice_q   <= indice_d;
      rodada_q   <= rodada_d;
      dado_q     <= dado_d;
      leds_q     <= leds_d;
      mem_addr_q <= indice_d;
      ocupado_q  <= ocupado_d;
      pronto_q   <= pronto_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.leds      = leds_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.pronto    = pronto_q;
  assign bus.db_estado = estado_q;
  assign bus.db_indice = indice_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with ON_CICLOS=4, OFF_CICLOS=2 and a
// 16x4 synchronous RAM model; expected timelines are computed from edge offsets.
module tb_exibidor_sequencia;
  import exibidor_sequencia_pkg::*;

  localparam int ON  = 4;
  localparam int OFF = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exibidor_sequencia_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  exibidor_sequencia #(
    .ON_CICLOS  (ON),
    .OFF_CICLOS (OFF),
    .ADDR_W     (4),
    .DATA_W     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [3:0] ram [16];
  always @(posedge clock) bus.mem_dado <= ram[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_game_ram();
    for (int i = 0; i < 16; i++) ram[i] = 4'h0;
    ram[0] = 4'hA;
    ram[1] = 4'h3;
    ram[2] = 4'h0;
    ram[3] = 4'hF;
  endtask

  // Pulses iniciar with rodada=r at edge k, then checks every cycle k+n.
  // Element e is lit for n in [3+9e, 6+9e]; pronto at n = 9r+10.
  task automatic run_sequence(input logic [3:0] r, input bit perturb);
    int         last;
    int         a;
    logic [3:0] exp_leds;
    logic [3:0] exp_addr;
    logic       exp_pronto;
    logic       exp_oc;
    logic [9:0] got;
    logic [9:0] exp;
    logic [3:0] exp_st;
    last = 9 * int'(r) + 10;
    bus.rodada  = r;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    for (int n = 0; n <= last + 2; n++) begin
      if (n > 0) step();
      exp_leds = 4'h0;
      for (int e = 0; e <= int'(r); e++)
        if (n >= 3 + 9 * e && n <= 6 + 9 * e) exp_leds = ram[e];
      a = n / 9;
      if (a > int'(r)) a = int'(r);
      exp_addr   = (n <= last - 1) ? 4'(a) : 4'h0;
      exp_pronto = (n == last);
      exp_oc     = (n >= 1 && n <= last);
      got = {bus.leds, bus.pronto, bus.ocupado, bus.mem_addr};
      exp = {exp_leds, exp_pronto, exp_oc, exp_addr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL seq r=%0d n=%0d: leds=%h pronto=%b ocupado=%b mem_addr=%0d, expected leds=%h pronto=%b ocupado=%b mem_addr=%0d",
                 r, n, bus.leds, bus.pronto, bus.ocupado, bus.mem_addr,
                 exp_leds, exp_pronto, exp_oc, exp_addr);
      end
      if (n <= 2 || n >= last - 1) begin
        case (n)
          0: exp_st = ENDERECA;
          1: exp_st = CAPTURA;
          2: exp_st = ACESO;
          default: exp_st = (n == last - 1) ? FIM : OCIOSO;
        endcase
        checks++;
        if (bus.db_estado !== exp_st) begin
          errors++;
          $display("FAIL seq_state r=%0d n=%0d: db_estado=%0d expected %0d",
                   r, n, bus.db_estado, exp_st);
        end
      end
      if (n == last) begin
        checks++;
        if (bus.db_indice !== 4'h0) begin
          errors++;
          $display("FAIL seq_indice_end r=%0d: db_indice=%0d expected 0", r, bus.db_indice);
        end
      end
      if (perturb) begin
        if (n == 4) begin
          bus.iniciar = 1'b1;
          bus.rodada  = (r == 4'd0) ? 4'd5 : 4'd0;
        end
        if (n == 5)        bus.iniciar = 1'b0;
        if (n == last - 1) bus.iniciar = 1'b1;
        if (n == last)     bus.iniciar = 1'b0;
      end
    end
    bus.iniciar = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] snap;
    bus.iniciar = 1'b0;
    bus.abortar = 1'b0;
    bus.rodada  = 4'h0;
    reset = 1'b0;
    #12;
    snap = {bus.leds, bus.pronto, bus.ocupado, bus.mem_addr, bus.db_estado, bus.db_indice};
    checks++;
    if (snap !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", snap);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    for (int i = 0; i < 50; i++) begin
      snap = {bus.leds, bus.pronto, bus.ocupado, bus.mem_addr, bus.db_estado, bus.db_indice};
      checks++;
      if (snap !== 18'h0) begin
        errors++;
        $display("FAIL idle_stable cycle %0d: got %h expected 0", i, snap);
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [3:0] r;
    r = 4'd3;
    bus.rodada  = r;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    for (int n = 1; n <= 13; n++) step();
    checks++;
    if (bus.leds !== 4'h3) begin
      errors++;
      $display("FAIL abort_pre_leds: leds=%h expected 3", bus.leds);
    end
    bus.abortar = 1'b1;
    step();
    bus.abortar = 1'b0;
    checks++;
    if ({bus.db_estado, bus.leds, bus.db_indice, bus.mem_addr, bus.ocupado, bus.pronto} !== 18'h0) begin
      errors++;
      $display("FAIL abort_effect: db_estado=%0d leds=%h db_indice=%0d mem_addr=%0d ocupado=%b pronto=%b expected all 0",
               bus.db_estado, bus.leds, bus.db_indice, bus.mem_addr, bus.ocupado, bus.pronto);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.pronto !== 1'b0 || bus.db_estado !== OCIOSO) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d: pronto=%b db_estado=%0d expected 0/0",
                 i, bus.pronto, bus.db_estado);
      end
    end
    // Abort together with start while idle: stays idle.
    bus.iniciar = 1'b1;
    bus.abortar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    bus.abortar = 1'b0;
    step();
    checks++;
    if (bus.db_estado !== OCIOSO || bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start: db_estado=%0d ocupado=%b expected 0/0",
               bus.db_estado, bus.ocupado);
    end
    run_sequence(4'd0, 1'b0);
  endtask

  task automatic test_reset_mid_sequence();
    load_game_ram();
    bus.rodada  = 4'd3;
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    for (int n = 1; n <= 7; n++) step();
    checks++;
    if (bus.db_estado !== APAGADO || bus.ocupado !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: db_estado=%0d ocupado=%b expected 4/1",
               bus.db_estado, bus.ocupado);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.db_estado, bus.leds, bus.db_indice, bus.mem_addr, bus.ocupado, bus.pronto} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_async: db_estado=%0d leds=%h db_indice=%0d mem_addr=%0d ocupado=%b pronto=%b expected all 0",
               bus.db_estado, bus.leds, bus.db_indice, bus.mem_addr, bus.ocupado, bus.pronto);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.db_estado !== OCIOSO || bus.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: db_estado=%0d ocupado=%b expected 0/0",
               bus.db_estado, bus.ocupado);
    end
  endtask

  initial begin
    load_game_ram();
    test_reset();
    run_sequence(4'd0, 1'b0);       // single element
    run_sequence(4'd3, 1'b0);       // A,3,0,F
    test_abort();
    run_sequence(4'd3, 1'b1);       // restart/rodada change ignored while busy and in FIM
    for (int i = 0; i < 16; i++) ram[i] = 4'(i);
    run_sequence(4'd15, 1'b0);      // full 16-element round
    test_reset_mid_sequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
